// File: rtl/xadc_chan_sequencer.sv
// Scan controller: walks enabled channels, settles the mux, runs a req/done conversion per channel.
// Optional build macro SEQ_AVG_EN: four back-to-back samples per channel, result is their mean.
module xadc_chan_sequencer #(
    parameter int unsigned NCH         = 8,
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic [7:0]        ch_mask,
    output logic [2:0]        chan,
    output logic              conv_req,
    input  logic              conv_done,
    input  logic [DATA_W-1:0] conv_data,
    output logic              res_valid,
    output logic [2:0]        res_ch,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              scan_done,
    output logic              timeout_err
);
    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned CNT_W = (SET_W > TO_W) ? SET_W : TO_W;
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0] VALID_MASK = 8'((16'h1 << NCH) - 16'h1);

    typedef enum logic [2:0] {
        IDLE,
        SEEK,
        SETTLE,
        CONVERT,
        STORE
    } state_t;

    state_t            state;
    logic [7:0]        mask_q;
    logic              first_pass;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] capt;
    logic [7:0]        eff_mask;
    logic [7:0]        remain;

`ifdef SEQ_AVG_EN
    localparam int unsigned ACC_W = DATA_W + 2;
    logic [1:0]       samp;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    assign sum = acc + ACC_W'(conv_data);
`endif

    // Lowest set bit index of a channel mask.
    function automatic logic [2:0] lowest_idx(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign eff_mask = ch_mask & VALID_MASK;
    // Channels still to visit this pass: strictly above the last serviced one.
    assign remain   = first_pass ? mask_q : (mask_q & (8'hFE << chan));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mask_q      <= 8'h00;
            first_pass  <= 1'b0;
            cnt         <= '0;
            capt        <= '0;
            chan        <= 3'd0;
            conv_req    <= 1'b0;
            res_valid   <= 1'b0;
            res_ch      <= 3'd0;
            res_data    <= '0;
            busy        <= 1'b0;
            scan_done   <= 1'b0;
            timeout_err <= 1'b0;
`ifdef SEQ_AVG_EN
            samp        <= 2'd0;
            acc         <= '0;
`endif
        end else begin
            res_valid <= 1'b0;
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (eff_mask != 8'h00)) begin
                        mask_q     <= eff_mask;
                        first_pass <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SEEK;
                    end
                end
                SEEK: begin
                    cnt        <= '0;
                    first_pass <= 1'b0;
                    if (remain != 8'h00) begin
                        chan  <= lowest_idx(remain);
                        state <= SETTLE;
                    end else begin
                        scan_done <= 1'b1;
                        // Mask is resampled only at a continuous restart.
                        if (continuous && (eff_mask != 8'h00)) begin
                            mask_q <= eff_mask;
                            chan   <= lowest_idx(eff_mask);
                            state  <= SETTLE;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt      <= '0;
                        conv_req <= 1'b1;
                        state    <= CONVERT;
`ifdef SEQ_AVG_EN
                        samp     <= 2'd0;
                        acc      <= '0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CONVERT: begin
                    if (conv_done) begin
`ifdef SEQ_AVG_EN
                        // conv_req stays high between the four samples.
                        cnt <= '0;
                        if (samp == 2'd3) begin
                            capt     <= sum[ACC_W-1:2];
                            conv_req <= 1'b0;
                            state    <= STORE;
                        end else begin
                            acc  <= sum;
                            samp <= samp + 2'd1;
                        end
`else
                        capt     <= conv_data;
                        conv_req <= 1'b0;
                        state    <= STORE;
`endif
                    end else if (cnt == TIMEOUT_LAST) begin
                        conv_req    <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= SEEK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STORE: begin
                    res_valid <= 1'b1;
                    res_ch    <= chan;
                    res_data  <= capt;
                    state     <= SEEK;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xadc_chan_sequencer.sv
// Directed bench for xadc_chan_sequencer; averaged-result scenario follows SEQ_AVG_EN.
module tb_xadc_chan_sequencer;
    localparam int unsigned DATA_W      = 12;
    localparam int unsigned SETTLE_CYC  = 16;
    localparam int unsigned TIMEOUT_CYC = 1024;
`ifdef SEQ_AVG_EN
    localparam int NSAMP = 4;
`else
    localparam int NSAMP = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              continuous;
    logic [7:0]        ch_mask;
    logic [2:0]        chan;
    logic              conv_req;
    logic              conv_done;
    logic [DATA_W-1:0] conv_data;
    logic              res_valid;
    logic [2:0]        res_ch;
    logic [DATA_W-1:0] res_data;
    logic              busy;
    logic              scan_done;
    logic              timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    xadc_chan_sequencer #(
        .NCH(8), .SETTLE_CYC(SETTLE_CYC), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .ch_mask(ch_mask),
        .chan(chan), .conv_req(conv_req), .conv_done(conv_done), .conv_data(conv_data),
        .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data), .busy(busy),
        .scan_done(scan_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; continuous = 1'b0; ch_mask = 8'h00;
        conv_done = 1'b0; conv_data = '0;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic pulse_start(input logic [7:0] m, input logic cont);
        ch_mask = m; continuous = cont; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Wait for conv_req, answer NSAMP conversions, return the result seen 2 cycles after the last done.
    task automatic serve_one(input int dly, input logic [DATA_W-1:0] base, input int inc,
                             output logic seen, output logic [2:0] req_ch, output logic got,
                             output logic [2:0] got_ch, output logic [DATA_W-1:0] got_data);
        int w;
        seen = 1'b0; req_ch = 3'd0; got = 1'b0; got_ch = 3'd0; got_data = '0;
        w = 0;
        while (conv_req !== 1'b1 && w < 400) begin
            step();
            w++;
        end
        if (conv_req !== 1'b1) return;
        seen = 1'b1;
        req_ch = chan;
        for (int k = 0; k < NSAMP; k++) begin
            repeat (dly) step();
            conv_done = 1'b1;
            conv_data = base + DATA_W'(k * inc);
            step();
            conv_done = 1'b0;
        end
        step();
        got = res_valid; got_ch = res_ch; got_data = res_data;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (chan !== 3'd0) begin n_bad++; $display("FAIL reset_chan: got %0d want 0", chan); end
        n_cmp++; if (conv_req !== 1'b0) begin n_bad++; $display("FAIL reset_conv_req: got %b want 0", conv_req); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        n_cmp++; if (scan_done !== 1'b0) begin n_bad++; $display("FAIL reset_scan_done: got %b want 0", scan_done); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        n_cmp++; if (res_data !== 12'h000) begin n_bad++; $display("FAIL reset_res_data: got %h want 000", res_data); end
    endtask

    task automatic test_latency();
        logic s, g; logic [2:0] rc, gc; logic [DATA_W-1:0] gd;
        do_reset();
        pulse_start(8'h08, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lat_busy_c1: got %b want 1", busy); end
        step();
        n_cmp++; if (chan !== 3'd3) begin n_bad++; $display("FAIL lat_chan_c2: got %0d want 3", chan); end
        repeat (SETTLE_CYC - 1) step();
        n_cmp++; if (conv_req !== 1'b0) begin n_bad++; $display("FAIL lat_req_c17: got %b want 0", conv_req); end
        step();
        n_cmp++; if (conv_req !== 1'b1) begin n_bad++; $display("FAIL lat_req_c18: got %b want 1", conv_req); end
        serve_one(0, 12'h5A5, 0, s, rc, g, gc, gd);
        n_cmp++; if (g !== 1'b1) begin n_bad++; $display("FAIL lat_res_valid: got %b want 1", g); end
        n_cmp++; if (gc !== 3'd3) begin n_bad++; $display("FAIL lat_res_ch: got %0d want 3", gc); end
        n_cmp++; if (gd !== 12'h5A5) begin n_bad++; $display("FAIL lat_res_data: got %h want 5a5", gd); end
        step();
        n_cmp++; if (scan_done !== 1'b1) begin n_bad++; $display("FAIL lat_scan_done: got %b want 1", scan_done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL lat_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_mid_reset();
        int w;
        do_reset();
        pulse_start(8'h04, 1'b0);
        w = 0;
        while (conv_req !== 1'b1 && w < 100) begin step(); w++; end
        n_cmp++; if (conv_req !== 1'b1) begin n_bad++; $display("FAIL mrst_req_seen: got %b want 1", conv_req); end
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (conv_req !== 1'b0) begin n_bad++; $display("FAIL mrst_conv_req: got %b want 0", conv_req); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mrst_busy: got %b want 0", busy); end
        n_cmp++; if (chan !== 3'd0) begin n_bad++; $display("FAIL mrst_chan: got %0d want 0", chan); end
        n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_res_valid: got %b want 0", res_valid); end
        step();
        rst = 1'b0;
        conv_done = 1'b1; conv_data = 12'h777;
        step();
        conv_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_late_done_%0d: got %b want 0", i, res_valid); end
        end
    endtask

    task automatic test_single_pass();
        logic s, g; logic [2:0] rc, gc; logic [DATA_W-1:0] gd;
        logic [2:0] exp_ch [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
        do_reset();
        pulse_start(8'b1010_0101, 1'b0);
        for (int i = 0; i < 4; i++) begin
            serve_one(3, DATA_W'(12'h300 + i), 0, s, rc, g, gc, gd);
            n_cmp++; if (rc !== exp_ch[i] || s !== 1'b1) begin n_bad++; $display("FAIL sp_req_ch_%0d: got %0d seen %b want %0d", i, rc, s, exp_ch[i]); end
            n_cmp++; if (g !== 1'b1 || gc !== exp_ch[i]) begin n_bad++; $display("FAIL sp_res_ch_%0d: got %0d valid %b want %0d", i, gc, g, exp_ch[i]); end
            n_cmp++; if (gd !== DATA_W'(12'h300 + i)) begin n_bad++; $display("FAIL sp_res_data_%0d: got %h want %h", i, gd, 12'h300 + i); end
        end
        step();
        n_cmp++; if (scan_done !== 1'b1) begin n_bad++; $display("FAIL sp_scan_done: got %b want 1", scan_done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sp_busy_end: got %b want 0", busy); end
        step();
        n_cmp++; if (scan_done !== 1'b0) begin n_bad++; $display("FAIL sp_scan_done_pulse: got %b want 0", scan_done); end
    endtask

    task automatic test_ignored_start();
        logic s, g; logic [2:0] rc, gc; logic [DATA_W-1:0] gd;
        logic activity;
        do_reset();
        pulse_start(8'h00, 1'b0);
        activity = 1'b0;
        repeat (25) begin
            if (busy !== 1'b0 || conv_req !== 1'b0) activity = 1'b1;
            step();
        end
        n_cmp++; if (activity !== 1'b0) begin n_bad++; $display("FAIL zm_activity: got %b want 0", activity); end
        pulse_start(8'h01, 1'b0);
        repeat (5) step();
        pulse_start(8'h02, 1'b0);
        serve_one(2, 12'h0F0, 0, s, rc, g, gc, gd);
        n_cmp++; if (g !== 1'b1 || gc !== 3'd0) begin n_bad++; $display("FAIL bs_res_ch: got %0d valid %b want 0", gc, g); end
        step();
        n_cmp++; if (scan_done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL bs_end: got scan_done %b busy %b want 1 0", scan_done, busy); end
        activity = 1'b0;
        repeat (30) begin
            if (conv_req !== 1'b0) activity = 1'b1;
            step();
        end
        n_cmp++; if (activity !== 1'b0) begin n_bad++; $display("FAIL bs_no_second_scan: got %b want 0", activity); end
    endtask

    task automatic test_continuous();
        logic s, g; logic [2:0] rc, gc; logic [DATA_W-1:0] gd;
        logic [2:0] exp_ch [6] = '{3'd0, 3'd7, 3'd0, 3'd7, 3'd1, 3'd1};
        do_reset();
        pulse_start(8'h81, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) ch_mask = 8'h02;
            serve_one(1, DATA_W'(12'h0A0 + i), 0, s, rc, g, gc, gd);
            n_cmp++; if (g !== 1'b1 || gc !== exp_ch[i]) begin n_bad++; $display("FAIL cont_res_ch_%0d: got %0d valid %b want %0d", i, gc, g, exp_ch[i]); end
            if (i == 5) continuous = 1'b0;
            if (i != 0 && i != 2) begin
                step();
                n_cmp++; if (scan_done !== 1'b1) begin n_bad++; $display("FAIL cont_scan_done_%0d: got %b want 1", i, scan_done); end
            end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cont_stop_busy: got %b want 0", busy); end
    endtask

    task automatic test_timeout();
        logic s, g; logic [2:0] rc, gc; logic [DATA_W-1:0] gd;
        int w, hi;
        logic saw_res;
        do_reset();
        pulse_start(8'h03, 1'b0);
        w = 0;
        while (conv_req !== 1'b1 && w < 100) begin step(); w++; end
        n_cmp++; if (conv_req !== 1'b1 || chan !== 3'd0) begin n_bad++; $display("FAIL to_first_req: got req %b chan %0d want 1 0", conv_req, chan); end
        hi = 0; saw_res = 1'b0;
        while (conv_req === 1'b1 && hi < 2000) begin
            hi++;
            if (res_valid === 1'b1) saw_res = 1'b1;
            step();
        end
        n_cmp++; if (hi != TIMEOUT_CYC) begin n_bad++; $display("FAIL to_req_cycles: got %0d want %0d", hi, TIMEOUT_CYC); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_err_set: got %b want 1", timeout_err); end
        serve_one(2, 12'h042, 0, s, rc, g, gc, gd);
        n_cmp++; if (rc !== 3'd1 || s !== 1'b1) begin n_bad++; $display("FAIL to_next_ch: got %0d seen %b want 1", rc, s); end
        n_cmp++; if (g !== 1'b1 || gd !== 12'h042) begin n_bad++; $display("FAIL to_next_res: got %h valid %b want 042", gd, g); end
        n_cmp++; if (saw_res !== 1'b0) begin n_bad++; $display("FAIL to_no_res: got %b want 0", saw_res); end
        step();
        n_cmp++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL to_sticky: got err %b busy %b want 1 0", timeout_err, busy); end
        do_reset();
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_cleared: got %b want 0", timeout_err); end
    endtask

    task automatic test_data();
        logic s, g; logic [2:0] rc, gc; logic [DATA_W-1:0] gd;
        logic extra;
        do_reset();
        pulse_start(8'h10, 1'b0);
`ifdef SEQ_AVG_EN
        serve_one(1, 12'h100, 1, s, rc, g, gc, gd);
        n_cmp++; if (g !== 1'b1 || gd !== 12'h101) begin n_bad++; $display("FAIL data_avg: got %h valid %b want 101", gd, g); end
`else
        serve_one(1, 12'hABC, 0, s, rc, g, gc, gd);
        n_cmp++; if (g !== 1'b1 || gd !== 12'hABC) begin n_bad++; $display("FAIL data_raw: got %h valid %b want abc", gd, g); end
`endif
        n_cmp++; if (gc !== 3'd4) begin n_bad++; $display("FAIL data_ch: got %0d want 4", gc); end
        extra = 1'b0;
        repeat (5) begin
            step();
            if (res_valid !== 1'b0) extra = 1'b1;
        end
        n_cmp++; if (extra !== 1'b0) begin n_bad++; $display("FAIL data_single_pulse: got %b want 0", extra); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_mid_reset();
        test_single_pass();
        test_ignored_start();
        test_continuous();
        test_timeout();
        test_data();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
